// File: rtl/codma_pkg.sv
// rtl/codma_pkg.sv - shared types and burst constants for the CODMA sequencer
package codma_pkg;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_ASK     = 2'd1,
        RD_GRANTED = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ASK     = 2'd1,
        WR_GRANTED = 2'd2
    } wr_state_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_t;

    localparam int BURST_WORDS = 8;
    localparam int BURST_BYTES = 32;

    // Beat counter that stops at a full burst so surplus beats are dropped.
    function automatic logic [3:0] beat_count_next(input logic [3:0] cnt,
                                                   input logic       hit,
                                                   input logic [3:0] full);
        return (hit && cnt < full) ? cnt + 4'd1 : cnt;
    endfunction

endpackage

// File: rtl/codma_burst_buffer.sv
// rtl/codma_burst_buffer.sv - burst-deep register file, one write port, one combinational read port
module codma_burst_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/codma_xfer_sequencer.sv
// rtl/codma_xfer_sequencer.sv - splits a copy task into read/write bursts for the CODMA bus machines
// Optional cycle counter output perf_cycles_o is built when CODMA_SEQ_PERF_EN is defined.
module codma_xfer_sequencer
    import codma_pkg::*;
#(
    parameter int BURST_WORDS = 8,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              need_read_o,
    output logic              need_write_o,
    input  rd_state_t         rd_state_i,
    input  wr_state_t         wr_state_i,
    output logic [3:0]        word_count_rd_o,
    output logic [3:0]        word_count_wr_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_rvalid_i,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_wready_i,
`ifdef CODMA_SEQ_PERF_EN
    output logic [31:0]       perf_cycles_o,
`endif
    input  logic              bus_error_i
);

    localparam int AW = $clog2(BURST_WORDS);
    localparam logic [3:0]        FULL_CNT = 4'(BURST_WORDS);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BURST_BYTES);

    seq_state_t        state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              need_read_q;
    logic              need_write_q;
    logic [3:0]        wc_rd;
    logic [3:0]        wc_wr;

    logic              start_bad;
    logic              rd_hit;
    logic              wr_hit;
    logic [DATA_W-1:0] buf_rdata;

    assign start_bad = (src_addr_i[4:0] != 5'd0) || (dst_addr_i[4:0] != 5'd0) ||
                       (len_i[4:0] != 5'd0);

    // A beat coinciding with bus_error_i is dropped: the error takes priority.
    assign rd_hit = (state == ST_READ) && bus_rvalid_i && (rd_state_i == RD_GRANTED) &&
                    !bus_error_i && (wc_rd < FULL_CNT);
    assign wr_hit = (state == ST_WRITE) && bus_wready_i && (wr_state_i == WR_GRANTED) &&
                    !bus_error_i && (wc_wr < FULL_CNT);

    codma_burst_buffer #(
        .DEPTH  (BURST_WORDS),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk_i),
        .we    (rd_hit),
        .waddr (wc_rd[AW-1:0]),
        .wdata (bus_rdata_i),
        .raddr (wc_wr[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state        <= ST_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            bus_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            need_read_q  <= 1'b0;
            need_write_q <= 1'b0;
            wc_rd        <= 4'd0;
            wc_wr        <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        error_q <= 1'b0;
                        wc_rd   <= 4'd0;
                        wc_wr   <= 4'd0;
                        if (start_bad) begin
                            state   <= ST_ERROR;
                            error_q <= 1'b1;
                        end else if (len_i == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state       <= ST_READ;
                            src_q       <= src_addr_i;
                            dst_q       <= dst_addr_i;
                            remaining_q <= len_i;
                            bus_addr_q  <= src_addr_i;
                            busy_q      <= 1'b1;
                            need_read_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (bus_error_i) begin
                        state        <= ST_ERROR;
                        error_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        need_read_q  <= 1'b0;
                        need_write_q <= 1'b0;
                        wc_rd        <= 4'd0;
                        wc_wr        <= 4'd0;
                    end else begin
                        if (rd_state_i == RD_ASK) begin
                            need_read_q <= 1'b0;
                        end
                        wc_rd <= beat_count_next(wc_rd, rd_hit, FULL_CNT);
                        if (wc_rd == FULL_CNT && rd_state_i == RD_IDLE) begin
                            state        <= ST_WRITE;
                            wc_wr        <= 4'd0;
                            need_read_q  <= 1'b0;
                            need_write_q <= 1'b1;
                            bus_addr_q   <= dst_q;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus_error_i) begin
                        state        <= ST_ERROR;
                        error_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        need_read_q  <= 1'b0;
                        need_write_q <= 1'b0;
                        wc_rd        <= 4'd0;
                        wc_wr        <= 4'd0;
                    end else begin
                        if (wr_state_i == WR_ASK) begin
                            need_write_q <= 1'b0;
                        end
                        wc_wr <= beat_count_next(wc_wr, wr_hit, FULL_CNT);
                        if (wc_wr == FULL_CNT && wr_state_i == WR_IDLE) begin
                            src_q        <= src_q + STEP;
                            dst_q        <= dst_q + STEP;
                            remaining_q  <= remaining_q - STEP;
                            wc_rd        <= 4'd0;
                            need_write_q <= 1'b0;
                            if (remaining_q == STEP) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end else begin
                                state       <= ST_READ;
                                need_read_q <= 1'b1;
                                bus_addr_q  <= src_q + STEP;
                            end
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                ST_ERROR: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef CODMA_SEQ_PERF_EN
    logic [31:0] perf_q;

    // busy_q is never set in IDLE, so the clear and the increment cannot collide.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            perf_q <= 32'd0;
        end else if (state == ST_IDLE && start_i) begin
            perf_q <= 32'd0;
        end else if (busy_q && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign need_read_o     = need_read_q & ~bus_error_i;
    assign need_write_o    = need_write_q & ~bus_error_i;
    assign word_count_rd_o = wc_rd;
    assign word_count_wr_o = wc_wr;
    assign bus_addr_o      = bus_addr_q;
    assign bus_wdata_o     = (state == ST_WRITE) ? buf_rdata : '0;

endmodule

// File: tb/tb_codma_xfer_sequencer.sv
// tb/tb_codma_xfer_sequencer.sv - directed self-checking bench for codma_xfer_sequencer
module tb_codma_xfer_sequencer;
    import codma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr, dst_addr, len;
    logic        busy, done, error, need_read, need_write;
    rd_state_t   rd_state;
    wr_state_t   wr_state;
    logic [3:0]  wc_rd, wc_wr;
    logic [31:0] bus_addr, bus_rdata, bus_wdata;
    logic        bus_rvalid, bus_wready, bus_error;
`ifdef CODMA_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    codma_xfer_sequencer dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .start_i         (start),
        .src_addr_i      (src_addr),
        .dst_addr_i      (dst_addr),
        .len_i           (len),
        .busy_o          (busy),
        .done_o          (done),
        .error_o         (error),
        .need_read_o     (need_read),
        .need_write_o    (need_write),
        .rd_state_i      (rd_state),
        .wr_state_i      (wr_state),
        .word_count_rd_o (wc_rd),
        .word_count_wr_o (wc_wr),
        .bus_addr_o      (bus_addr),
        .bus_rdata_i     (bus_rdata),
        .bus_rvalid_i    (bus_rvalid),
        .bus_wdata_o     (bus_wdata),
        .bus_wready_i    (bus_wready),
`ifdef CODMA_SEQ_PERF_EN
        .perf_cycles_o   (perf_cycles),
`endif
        .bus_error_i     (bus_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " error"}, 32'(error), 32'd0);
        check({tag, " need_read"}, 32'(need_read), 32'd0);
        check({tag, " need_write"}, 32'(need_write), 32'd0);
        check({tag, " wc_rd"}, 32'(wc_rd), 32'd0);
        check({tag, " wc_wr"}, 32'(wc_wr), 32'd0);
        check({tag, " bus_addr"}, bus_addr, 32'd0);
        check({tag, " bus_wdata"}, bus_wdata, 32'd0);
    endtask

    task automatic start_task(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_need_read();
        int t = 0;
        while (!need_read && t < 20) begin @(negedge clk); t++; end
        if (!need_read) check("need_read timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_need_write();
        int t = 0;
        while (!need_write && t < 20) begin @(negedge clk); t++; end
        if (!need_write) check("need_write timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int nbeats, input logic [31:0] base);
        wait_need_read();
        check("rd bus_addr", bus_addr, addr);
        rd_state = RD_ASK;
        @(negedge clk);
        check("need_read released", 32'(need_read), 32'd0);
        rd_state = RD_GRANTED;
        for (int i = 0; i < nbeats; i++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = base + 32'(i);
            @(negedge clk);
            check("wc_rd", 32'(wc_rd), (i + 1 > 8) ? 32'd8 : 32'(i + 1));
        end
        bus_rvalid = 1'b0;
        rd_state   = RD_IDLE;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] base);
        wait_need_write();
        check("wr bus_addr", bus_addr, addr);
        check("wc_wr cleared", 32'(wc_wr), 32'd0);
        wr_state = WR_ASK;
        @(negedge clk);
        check("need_write released", 32'(need_write), 32'd0);
        wr_state = WR_GRANTED;
        for (int i = 0; i < 8; i++) begin
            check("wdata", bus_wdata, base + 32'(i));
            bus_wready = 1'b1;
            @(negedge clk);
            check("wc_wr", 32'(wc_wr), 32'(i + 1));
        end
        bus_wready = 1'b0;
        wr_state   = WR_IDLE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        rd_state = RD_IDLE; wr_state = WR_IDLE;
        bus_rdata = '0; bus_rvalid = 1'b0; bus_wready = 1'b0; bus_error = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Two-burst copy
        start_task(32'h100, 32'h800, 32'd64);
        check("t1 busy", 32'(busy), 32'd1);
        do_read(32'h100, 8, 32'hA5A5_0000);
        do_write(32'h800, 32'hA5A5_0000);
        @(negedge clk);
        check("t1 mid done", 32'(done), 32'd0);
        check("t1 mid busy", 32'(busy), 32'd1);
        do_read(32'h120, 8, 32'h5A5A_1000);
        do_write(32'h820, 32'h5A5A_1000);
        @(negedge clk);
        check("t1 done", 32'(done), 32'd1);
        check("t1 busy end", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1 done pulse", 32'(done), 32'd0);

        // Zero length
        start_task(32'h0, 32'h0, 32'd0);
        check("t2 done", 32'(done), 32'd1);
        check("t2 need_read", 32'(need_read), 32'd0);
        check("t2 busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t2 done pulse", 32'(done), 32'd0);

        // Bad length, then bad alignment
        start_task(32'h100, 32'h800, 32'd40);
        check("t3 len error", 32'(error), 32'd1);
        check("t3 len need_read", 32'(need_read), 32'd0);
        @(negedge clk);
        start_task(32'h104, 32'h800, 32'd64);
        check("t3 align error", 32'(error), 32'd1);
        check("t3 align busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t3 no need_read", 32'(need_read), 32'd0);

        // Bus error on read beat 3
        start_task(32'h200, 32'h900, 32'd32);
        check("t4 error cleared", 32'(error), 32'd0);
        rd_state = RD_ASK;
        @(negedge clk);
        rd_state = RD_GRANTED;
        for (int i = 0; i < 3; i++) begin
            bus_rvalid = 1'b1; bus_rdata = 32'(i);
            @(negedge clk);
        end
        check("t4 wc_rd before err", 32'(wc_rd), 32'd3);
        bus_error = 1'b1;
        #1;
        check("t4 need_write gated", 32'(need_write), 32'd0);
        @(negedge clk);
        bus_error = 1'b0; bus_rvalid = 1'b0; rd_state = RD_IDLE;
        check("t4 error", 32'(error), 32'd1);
        check("t4 busy", 32'(busy), 32'd0);
        check("t4 wc_rd", 32'(wc_rd), 32'd0);
        @(negedge clk);
        start_task(32'h200, 32'h900, 32'd32);
        check("t4b error cleared", 32'(error), 32'd0);
        check("t4b need_read", 32'(need_read), 32'd1);
        bus_error = 1'b1;
        #1;
        check("t4b need_read gated", 32'(need_read), 32'd0);
        @(negedge clk);
        bus_error = 1'b0;
        check("t4b error", 32'(error), 32'd1);
        @(negedge clk);
        start_task(32'h0, 32'h0, 32'd0);
        check("t4 restart clears error", 32'(error), 32'd0);
        check("t4 restart done", 32'(done), 32'd1);
        @(negedge clk);

        // Surplus read beats
        start_task(32'h300, 32'hA00, 32'd32);
        do_read(32'h300, 10, 32'hC0DE_0000);
        do_write(32'hA00, 32'hC0DE_0000);
        @(negedge clk);
        check("t5 done", 32'(done), 32'd1);
        @(negedge clk);

        // Reset during write beat 5
        start_task(32'h400, 32'hB00, 32'd32);
        do_read(32'h400, 8, 32'h1234_0000);
        wait_need_write();
        wr_state = WR_ASK;
        @(negedge clk);
        wr_state = WR_GRANTED;
        for (int i = 0; i < 5; i++) begin
            bus_wready = 1'b1;
            @(negedge clk);
        end
        check("t6 wc_wr before reset", 32'(wc_wr), 32'd5);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("t6 reset");
        reset_n = 1'b1; bus_wready = 1'b0; wr_state = WR_IDLE;
        @(negedge clk);
        check("t6 no done", 32'(done), 32'd0);
        check("t6 no error", 32'(error), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
